icache_fill: RTL
================

ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 rd_req  input  1  fetch stage requests an instruction at addr this cycle.
REQ-004 addr  input  16  byte address from PC; bit 0 ignored.
REQ-005 data_out  output  16  instruction word to IF/ID register.
REQ-006 stall  output  1  fetch stage shall hold PC and IF/ID contents while high.
REQ-007 mem_rd  output  1  one-cycle read request to multi-cycle main memory.
REQ-008 mem_addr  output  16  word-aligned byte address of the current memory request.
REQ-009 mem_data  input  16  word returned by main memory.
REQ-010 mem_valid  input  1  mem_data valid this cycle; responses arrive in request order.

Function
REQ-011 Organisation SHALL be direct-mapped: 32 lines x 16 bytes (8 words); offset addr[3:1], index addr[8:4], tag addr[15:9] (7 bits).
REQ-012 Hit SHALL be rd_req & valid[index] & (tag_array[index] == addr[15:9]) & state==IDLE, evaluated combinationally.
REQ-013 On hit, data_out SHALL present data[index][offset] in the same cycle (zero-latency) and stall SHALL be 0.
REQ-014 When rd_req is low, stall SHALL be 0 and data_out SHALL be 16'h0000.
REQ-015 On miss (rd_req & ~hit in IDLE), stall SHALL be 1 in the same cycle; data_out SHALL be 16'h0000 during every stall cycle.
REQ-016 FSM states: IDLE, FILL, WAIT.
REQ-017 IDLE -> FILL on miss; the block SHALL latch the miss tag and index at that edge.
REQ-018 FILL: mem_rd=1 on each of 8 consecutive cycles, mem_addr = {latched tag, latched index, issue_cnt[2:0], 1'b0}, issue_cnt counting 0..7; after issue 7 -> WAIT.
REQ-019 Returned words SHALL be written into data[latched index][recv_cnt] on each mem_valid, recv_cnt counting 0..7, in FILL or WAIT.
REQ-020 On the edge where the 8th word (recv_cnt==7 & mem_valid) is written, the block SHALL set valid and write tag for that line and go to IDLE; the retried fetch SHALL hit the following cycle.
REQ-021 stall SHALL be 1 in every cycle with state FILL or WAIT.
REQ-022 Block SHALL not depend on memory latency; it SHALL tolerate mem_valid arriving in the same cycles requests are still issuing.
REQ-023 Changes on addr/rd_req during FILL/WAIT SHALL be ignored; the fill always completes for the latched line.
REQ-024 mem_valid outside FILL/WAIT SHALL be ignored (no array write).
REQ-025 A miss replacing a valid line SHALL overwrite it entirely; no partially-filled line SHALL ever read as valid (valid cleared at IDLE->FILL for that index).
REQ-026 mem_rd SHALL be 0 in IDLE and WAIT.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, issue_cnt=0, recv_cnt=0, all 32 valid bits=0, stall=0, mem_rd=0, data_out=0.
REQ-028 Tag and data arrays need not be reset.
REQ-029 Reset asserted mid-fill SHALL abandon the fill; memory responses arriving after rst_n rises SHALL be ignored per REQ-024.

Structure
REQ-030 Shared package icache_pkg SHALL hold LINES=32, WORDS_PER_LINE=8, TAG_W=7, IDX_W=5, OFF_W=3 and the state enumeration.
REQ-031 Data/tag/valid storage SHALL be one sub-module icache_array (combinational read, synchronous write, async valid clear); FSM and counters stay in icache_fill.

Verification
REQ-032 Reset, rd_req=1, addr=16'h0000, memory 4-cycle latency returning word i = 16'hA000+i -> stall high 12 cycles, 8 mem_rd pulses at 0x0000..0x000E, then data_out=16'hA000, stall=0.
REQ-033 After REQ-032, addr=16'h000E -> hit same cycle, data_out=16'hA007, no mem_rd.
REQ-034 addr=16'h0200 (same index 0, tag 1) -> miss, refill; then addr=16'h0000 -> miss again (conflict eviction).
REQ-035 Change addr to 16'h0010 in 3rd FILL cycle -> mem_addr continues 0x0000-based sequence; 0x0010 misses only after return to IDLE.
REQ-036 Assert rst_n low during WAIT after 5 words returned, deassert, then addr=16'h0000 -> miss (line not valid), full 8-word refill.
REQ-037 Inject spurious mem_valid=1, mem_data=16'hDEAD in IDLE -> no array change; subsequent hit returns original data.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry, state encoding and address helpers for the instruction-cache fill block.
package icache_pkg;

    localparam int LINES          = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int TAG_W          = 7;
    localparam int IDX_W          = 5;
    localparam int OFF_W          = 3;
    localparam int DATA_W         = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FILL = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    // Word-aligned byte address of one word inside a line.
    function automatic logic [15:0] fill_addr(
        input logic [TAG_W-1:0] tag,
        input logic [IDX_W-1:0] idx,
        input logic [OFF_W-1:0] off
    );
        return {tag, idx, off, 1'b0};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/data/valid storage: combinational read, synchronous write,
// valid bits cleared asynchronously by reset.
module icache_array
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic              rd_valid_o,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic              wr_en_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              line_clr_i,
    input  logic              line_set_i,
    input  logic [TAG_W-1:0]  line_tag_i
);

    logic [DATA_W-1:0] data_q [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;

    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

    // Valid next-state: cleared when a refill starts, set when its last word lands.
    always_comb begin
        valid_d = valid_q;
        if (line_clr_i) begin
            valid_d[wr_idx_i] = 1'b0;
        end else if (line_set_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only storage that needs a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and tag arrays: plain synchronous write ports.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (line_set_i) begin
            tag_q[wr_idx_i] <= line_tag_i;
        end
    end

endmodule

// File: rtl/icache_fill.sv
// Blocking direct-mapped instruction cache: zero-latency hits, 8-word line
// refill from an in-order multi-cycle memory on a miss.
module icache_fill
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [15:0] addr,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_valid
);

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [OFF_W-1:0]   a_off_s;
    logic [IDX_W-1:0]   a_idx_s;
    logic [TAG_W-1:0]   a_tag_s;
    logic [DATA_W-1:0]  arr_data_s;
    logic [TAG_W-1:0]   arr_tag_s;
    logic               arr_valid_s;
    logic               req_s, idle_s, hit_s, miss_s;
    logic               fill_active_s, wr_en_s, last_word_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               unused_s;

    assign a_off_s  = addr[3:1];
    assign a_idx_s  = addr[8:4];
    assign a_tag_s  = addr[15:9];
    assign unused_s = addr[0];

    // A request seen while reset is held must not raise stall.
    assign req_s         = rd_req & rst_n;
    assign idle_s        = (state_q == ST_IDLE);
    assign hit_s         = req_s & arr_valid_s & (arr_tag_s == a_tag_s) & idle_s;
    assign miss_s        = req_s & ~hit_s & idle_s;
    assign fill_active_s = (state_q == ST_FILL) | (state_q == ST_WAIT);
    assign wr_en_s       = fill_active_s & mem_valid;
    assign last_word_s   = wr_en_s & (recv_cnt_q == 3'd7);
    assign wr_idx_s      = fill_active_s ? idx_q : a_idx_s;

    assign stall    = ~idle_s | miss_s;
    assign data_out = hit_s ? arr_data_s : 16'h0000;
    assign mem_rd   = (state_q == ST_FILL);
    assign mem_addr = fill_addr(tag_q, idx_q, issue_cnt_q);

    icache_array u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (a_idx_s),
        .rd_off_i   (a_off_s),
        .rd_data_o  (arr_data_s),
        .rd_tag_o   (arr_tag_s),
        .rd_valid_o (arr_valid_s),
        .wr_idx_i   (wr_idx_s),
        .wr_en_i    (wr_en_s),
        .wr_off_i   (recv_cnt_q),
        .wr_data_i  (mem_data),
        .line_clr_i (miss_s),
        .line_set_i (last_word_s),
        .line_tag_i (tag_q)
    );

    // Next-state logic for the fill FSM, the latched line and both counters.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        tag_d       = tag_q;
        idx_d       = idx_q;

        if (wr_en_s) begin
            recv_cnt_d = recv_cnt_q + 3'd1;
        end else begin
            recv_cnt_d = recv_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (miss_s) begin
                    state_d     = ST_FILL;
                    tag_d       = a_tag_s;
                    idx_d       = a_idx_s;
                    issue_cnt_d = 3'd0;
                    recv_cnt_d  = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                issue_cnt_d = issue_cnt_q + 3'd1;
                // A zero-latency memory could finish the line before issuing ends.
                if (last_word_s) begin
                    state_d = ST_IDLE;
                end else if (issue_cnt_q == 3'd7) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WAIT: begin
                if (last_word_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            tag_q       <= 7'd0;
            idx_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
        end
    end

endmodule
